instr_encode_loader: RTL and testbench
======================================

INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of instruction word 0.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the instruction-memory size in words (power of two).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1: pulse that begins a load session.
REQ-006 Port len, input, 8: number of instructions in the session, sampled on the accepted start.
REQ-007 Port in_valid, input, 1: an instruction descriptor is present.
REQ-008 Port in_ready, output, 1: the block accepts the descriptor this cycle.
REQ-009 Port kind, input, 2: 00 load (I), 01 store (S), 10 R-type, 11 branch (B).
REQ-010 Ports rd, rs1, rs2, input, 5 each: register fields.
REQ-011 Port funct3, input, 3; port funct7_5, input, 1: R-type sub/sra select.
REQ-012 Port imm, input, 12: imm[11:0] for I/S; offset[12:1] for B.
REQ-013 Ports imem_we (1), imem_addr (32), imem_wdata (32), outputs: instruction-memory write port.
REQ-014 Ports busy (1), done (1), err (1), outputs: session active, one-cycle completion pulse, sticky illegal flag.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE->RUN on start with len!=0; IDLE->DONE on start with len==0; start in RUN/DONE is ignored.
REQ-017 in_ready SHALL equal (state==RUN); a beat transfers when in_valid && in_ready.
REQ-018 Each transferred beat SHALL produce exactly one write: imem_we=1 on the next cycle, imem_wdata and imem_addr registered, back-to-back at 1 word/cycle.
REQ-019 Encodings: load {imm,rs1,funct3,rd,0000011}; store {imm[11:5],rs2,rs1,funct3,imm[4:0],0100011}; R {0,funct7_5,00000,rs2,rs1,funct3,rd,0110011}; branch {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],1100011}.
REQ-020 Word index SHALL start at 0 per session; imem_addr = BASE_ADDR + 4*index; index wraps modulo DEPTH.
REQ-021 After the len-th beat transfers, the state SHALL be RUN->DONE, so that in_ready drops the following cycle.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; for len>0 done coincides with the last imem_we.
REQ-023 busy SHALL be 1 in RUN and DONE.
REQ-024 Illegal descriptor (R-type with funct7_5=1 and funct3 not 000/101; load/store funct3 not in {000,001,010,100,101}/{000,001,010}; branch funct3 010/011) SHALL write 32'h0000_0000 and set err.
REQ-025 err SHALL clear only on reset or an accepted start.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE, index=0, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0.
REQ-027 Reset mid-session SHALL abort without further writes; a pending registered write SHALL NOT occur.

Structure
REQ-028 Opcode constants (0000011, 0100011, 0110011, 1100011) and kind encodings SHALL live in the shared package also used by the main decoder.
REQ-029 Combinational field packing SHALL be sub-module instr_field_encoder; FSM, counters, and registers SHALL stay in the top module.

Verification
REQ-030 The bench SHALL cover: start len=1, load rd=5 rs1=2 imm=8 funct3=010 -> one write, wdata 0x00812283 at addr BASE_ADDR, done the same cycle.
REQ-031 The bench SHALL cover: len=3 back-to-back store rs2=6 rs1=2 imm=12 f3=010, R add rd=3 rs1=1 rs2=2, R sub -> 0x00612623, 0x002081B3, 0x402081B3 at +0, +4, +8.
REQ-032 The bench SHALL cover: branch rs1=1 rs2=2 f3=000 imm=12'hFFE -> 0xFE208EE3.
REQ-033 The bench SHALL cover: DEPTH=4, len=6 -> addresses 0,4,8,12,0,4; in_valid gaps stall without writes.
REQ-034 The bench SHALL cover: len=0 -> done pulse, no imem_we; R f7_5=1 f3=001 -> wdata 0, err=1 until the next start.
REQ-035 The bench SHALL cover: reset asserted the cycle after a transfer -> no imem_we, all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader and the main decoder.
// Holds the descriptor kind encodings, the major opcodes, the loader FSM state
// type and the descriptor legality rule.
package instr_encode_loader_pkg;

  // Descriptor kind as presented on the loader's kind port.
  typedef enum logic [1:0] {
    KIND_LOAD   = 2'b00,
    KIND_STORE  = 2'b01,
    KIND_RTYPE  = 2'b10,
    KIND_BRANCH = 2'b11
  } kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A descriptor is legal when its funct3 (and funct7[5] for R-type) names a
  // real instruction of that kind.
  function automatic logic desc_legal(input logic [1:0] kind,
                                      input logic [2:0] funct3,
                                      input logic       funct7_5);
    logic ok;
    ok = 1'b0;
    case (kind)
      KIND_LOAD:   ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      KIND_STORE:  ok = funct3 inside {3'b000, 3'b001, 3'b010};
      KIND_RTYPE:  ok = !funct7_5 || (funct3 inside {3'b000, 3'b101});
      default:     ok = !(funct3 inside {3'b010, 3'b011});
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encode_loader_field_encoder.sv
// instr_field_encoder: combinational packing of one instruction descriptor
// into a 32-bit RV32 instruction word.
//   kind_i      descriptor kind (load/store/R-type/branch)
//   rd_i/rs1_i/rs2_i, funct3_i, funct7_5_i, imm_i   descriptor fields
//   word_o      packed instruction, all-zero when the descriptor is illegal
//   illegal_o   descriptor does not name a real instruction
module instr_field_encoder
  import instr_encode_loader_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic legal;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    legal  = desc_legal(kind_i, funct3_i, funct7_5_i);
    word_o = '0;
    case (kind_i)
      KIND_LOAD:  word_o = {imm_i, rs1_i, funct3_i, rd_i, OPC_LOAD};
      KIND_STORE: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
      KIND_RTYPE: word_o = {1'b0, funct7_5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      // For branches imm_i carries offset[12:1], so imm_i[11] is offset[12].
      default:    word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                            imm_i[3:0], imm_i[10], OPC_BRANCH};
    endcase
    if (!legal) word_o = '0;
    illegal_o = !legal;
  end

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: accepts a session of instruction descriptors, encodes
// each one and writes it to consecutive words of an instruction memory.
//   clk, reset              clock, asynchronous active-high reset
//   start, len              begin a session of len descriptors (len sampled)
//   in_valid / in_ready     descriptor handshake, one beat per cycle
//   kind..imm               descriptor fields
//   imem_we/addr/wdata      registered instruction-memory write port
//   busy, done, err         session active, completion pulse, sticky illegal
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [11:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The mask only matters for DEPTH==1, where the index must stay at zero.
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);

  state_e           state_q;
  logic [7:0]       len_q;
  logic [7:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        xfer;
  logic        last_beat;

  instr_field_encoder u_enc (
    .kind_i     (kind),
    .rd_i       (rd),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .imm_i      (imm),
    .word_o     (enc_word),
    .illegal_o  (enc_illegal)
  );

  assign in_ready  = (state_q == ST_RUN);
  assign xfer      = in_valid && in_ready;
  // len_q is nonzero whenever RUN is entered, so cnt_q+1 reaches it exactly once.
  assign last_beat = ((cnt_q + 8'd1) == len_q);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        we_q    <= 1'b1;
        addr_q  <= BASE_ADDR + (32'(idx_q & IDX_MASK) << 2);
        wdata_q <= enc_word;
        idx_q   <= idx_q + IDX_W'(1);
        cnt_q   <= cnt_q + 8'd1;
        if (enc_illegal) err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= len;
            state_q <= (len == 8'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN:  if (xfer && last_beat) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed sessions with known
// instruction words, address wrap, gaps, illegal descriptors, reset abort and
// randomized sessions compared against an arithmetic reference encoder.
module tb_instr_encode_loader;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [11:0] imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;

  always #5 clk = ~clk;

  instr_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] imm;
    bit          has_lit;
    logic [31:0] lit;
  } desc_t;

  desc_t descs[$];
  int    total   = 0;
  int    bad     = 0;
  int    wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts every write the memory would see; holding reset must block writes.
  always @(negedge clk) begin
    if (reset) check("we_during_reset", 32'(imem_we), 32'd0);
    else if (imem_we) wr_seen++;
  end

  // Reference encoder built from the field positions with plain arithmetic.
  function automatic void ref_encode(input desc_t d, output logic [31:0] w, output bit ill);
    longint unsigned v;
    int f3;
    f3 = int'(d.f3);
    v  = 0;
    case (int'(d.kind))
      0: begin
        ill = !(f3 inside {0, 1, 2, 4, 5});
        v = 64'(d.imm) * 2**20 + 64'(d.rs1) * 2**15 + 64'(f3) * 2**12 + 64'(d.rd) * 2**7 + 3;
      end
      1: begin
        ill = !(f3 inside {0, 1, 2});
        v = 64'(d.imm / 32) * 2**25 + 64'(d.rs2) * 2**20 + 64'(d.rs1) * 2**15
          + 64'(f3) * 2**12 + 64'(d.imm % 32) * 2**7 + 35;
      end
      2: begin
        ill = d.f7 && !(f3 inside {0, 5});
        v = 64'(d.f7) * 2**30 + 64'(d.rs2) * 2**20 + 64'(d.rs1) * 2**15
          + 64'(f3) * 2**12 + 64'(d.rd) * 2**7 + 51;
      end
      default: begin
        ill = (f3 inside {2, 3});
        v = 64'(d.imm / 2048) * 64'h8000_0000 + 64'((d.imm / 16) % 64) * 2**25
          + 64'(d.rs2) * 2**20 + 64'(d.rs1) * 2**15 + 64'(f3) * 2**12
          + 64'(d.imm % 16) * 2**8 + 64'((d.imm / 1024) % 2) * 2**7 + 99;
      end
    endcase
    w = ill ? 32'd0 : v[31:0];
  endfunction

  function automatic desc_t mk(input int k, input int rd_v, input int rs1_v, input int rs2_v,
                               input int f3_v, input int f7_v, input int imm_v,
                               input bit has_lit, input logic [31:0] lit);
    desc_t d;
    d.kind = 2'(k);  d.rd = 5'(rd_v); d.rs1 = 5'(rs1_v); d.rs2 = 5'(rs2_v);
    d.f3 = 3'(f3_v); d.f7 = 1'(f7_v); d.imm = 12'(imm_v);
    d.has_lit = has_lit; d.lit = lit;
    return d;
  endfunction

  function automatic desc_t rnd_desc();
    return mk(int'($urandom_range(3)), int'($urandom_range(31)), int'($urandom_range(31)),
              int'($urandom_range(31)), int'($urandom_range(7)), int'($urandom_range(1)),
              int'($urandom_range(4095)), 1'b0, 32'd0);
  endfunction

  task automatic drive_fields(input desc_t d);
    kind = d.kind; rd = d.rd; rs1 = d.rs1; rs2 = d.rs2;
    funct3 = d.f3; funct7_5 = d.f7; imm = d.imm;
  endtask

  // Runs one session over the descriptors in descs. gap_odd inserts an idle
  // cycle before every odd beat; gap_pct adds random idle cycles; noisy
  // toggles start during the session, which must be ignored.
  task automatic run_session(input int n, input bit gap_odd, input int gap_pct, input bit noisy);
    int          sent;
    int          wr_before;
    bit          exp_err;
    bit          ill;
    logic [31:0] w;
    sent = 0; exp_err = 1'b0; wr_before = wr_seen;
    start = 1'b1; len = 8'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_clear_on_start", 32'(err), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), (n == 0) ? 32'd0 : 32'd1);
    if (n == 0) begin
      check("done_len0", 32'(done), 32'd1);
      check("we_len0", 32'(imem_we), 32'd0);
    end
    while (sent < n) begin
      if ((gap_odd && (sent % 2 == 1) && in_valid) || (int'($urandom_range(99)) < gap_pct)) begin
        in_valid = 1'b0;
        drive_fields(rnd_desc());
        @(posedge clk); #1;
        check("no_write_on_gap", 32'(imem_we), 32'd0);
        check("ready_held_on_gap", 32'(in_ready), 32'd1);
      end else begin
        check("ready_for_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        drive_fields(descs[sent]);
        if (noisy) begin start = 1'($urandom_range(1)); len = 8'($urandom_range(255)); end
        ref_encode(descs[sent], w, ill);
        exp_err = exp_err | ill;
        @(posedge clk); #1;
        start = 1'b0;
        check("we_after_beat", 32'(imem_we), 32'd1);
        check("wr_addr", imem_addr, BASE + 32'(4 * (sent % DEPTH)));
        check("wr_data", imem_wdata, w);
        if (descs[sent].has_lit) check("wr_data_literal", imem_wdata, descs[sent].lit);
        sent++;
      end
    end
    in_valid = 1'b0;
    if (n > 0) begin
      check("done_with_last_write", 32'(done), 32'd1);
      check("ready_drops", 32'(in_ready), 32'd0);
      check("err_after_session", 32'(err), 32'(exp_err));
    end
    // A start in DONE must be ignored: the block still returns to IDLE.
    start = 1'b1; len = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("no_extra_write", 32'(imem_we), 32'd0);
    check("err_held_in_idle", 32'(err), 32'(exp_err));
    check("write_count", 32'(wr_seen - wr_before), 32'(n));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, BASE);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int wr_before;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 1'b0, 32'd0));
    #1;
    check_reset_values("reset0");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Single load.
    descs = {};
    descs.push_back(mk(0, 5, 2, 0, 2, 0, 8, 1'b1, 32'h0081_2283));
    run_session(1, 1'b0, 0, 1'b0);

    // Store, add, sub back to back.
    descs = {};
    descs.push_back(mk(1, 0, 2, 6, 2, 0, 12, 1'b1, 32'h0061_2623));
    descs.push_back(mk(2, 3, 1, 2, 0, 0, 0, 1'b1, 32'h0020_81B3));
    descs.push_back(mk(2, 3, 1, 2, 0, 1, 0, 1'b1, 32'h4020_81B3));
    run_session(3, 1'b0, 0, 1'b0);

    // Branch with negative offset.
    descs = {};
    descs.push_back(mk(3, 0, 1, 2, 0, 0, 12'hFFE, 1'b1, 32'hFE20_8EE3));
    run_session(1, 1'b0, 0, 1'b0);

    // Six beats through a four-word memory, with stalls.
    descs = {};
    for (int i = 0; i < 6; i++) descs.push_back(mk(0, i + 1, 3, 0, 2, 0, 4 * i, 1'b0, 32'd0));
    run_session(6, 1'b1, 0, 1'b0);

    // Illegal R-type writes zero and sets a sticky err.
    descs = {};
    descs.push_back(mk(2, 4, 1, 2, 1, 1, 0, 1'b1, 32'h0000_0000));
    descs.push_back(mk(0, 5, 2, 0, 2, 0, 8, 1'b1, 32'h0081_2283));
    run_session(2, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("err_sticky_idle", 32'(err), 32'd1);

    // Empty session: done pulse, no write, err cleared by the start.
    run_session(0, 1'b0, 0, 1'b0);

    // Reset the cycle after an (illegal) transfer aborts the pending write.
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wr_before = wr_seen;
    in_valid = 1'b1;
    drive_fields(mk(2, 4, 1, 2, 1, 1, 0, 1'b0, 32'd0));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_values("reset_abort");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_no_write", 32'(wr_seen - wr_before), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Randomized sessions against the reference encoder.
    for (int s = 0; s < 5; s++) begin
      int n;
      n = int'($urandom_range(12, 1));
      descs = {};
      for (int i = 0; i < n; i++) descs.push_back(rnd_desc());
      run_session(n, 1'b0, 30, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
